stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
Parametrised, single-clock successor to the team's width-reducing serializer. It accepts INWIDTH-bit words with a per-word beat count over a valid/ready handshake and emits OUTWIDTH-bit beats over a second valid/ready handshake. Beat order is selectable (LSB-first or MSB-first), and out_last is flagged on the final beat of each word. A one-word pending buffer lets words stream back-to-back without bubbles. It sits between the Haraka permutation output and byte-oriented sinks (UART/AXI-Stream bridges).

Parameters:
INWIDTH, 256, input word width; must be an integer multiple of OUTWIDTH.
OUTWIDTH, 8, output beat width.
MSB_FIRST, 0, 0: first beat is in_data[OUTWIDTH-1:0]; 1: first beat is in_data[INWIDTH-1:INWIDTH-OUTWIDTH].
BEATS, INWIDTH/OUTWIDTH, localparam; maximum beats per word.
LENW, $clog2(BEATS+1), localparam; width of the length field.

Ports:
clk  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_data  input  INWIDTH  word to serialize.
in_len  input  LENW  number of beats to emit for this word (0..2^LENW-1).
in_valid  input  1  in_data/in_len are valid.
in_ready  output  1  block can accept a word this cycle.
out_data  output  OUTWIDTH  current beat.
out_valid  output  1  out_data is valid.
out_ready  input  1  sink accepts the beat.
out_last  output  1  current beat is the last beat of its word.
busy  output  1  shifter or pending buffer holds data.

Behaviour:
- Storage: a shifter (shift_reg, beat counter cnt) plus a pending register (pend_data, pend_len, pend_valid).
- Reset (reset==0, async): shift_reg=0, cnt=0, pend_valid=0, pend_len=0, out_data=0, out_valid=0, out_last=0. busy=0. in_ready=1 is permitted during and after reset.
- in_ready = !pend_valid, a combinational function of registered state only. No dependency on in_valid or out_ready.
- Input handshake: transfer occurs on any edge where in_valid && in_ready.
- Length rules:
  - in_len > BEATS is clamped to BEATS.
  - in_len == 0: the word is accepted and silently dropped. It produces no beats and occupies no storage.
- Accepted-word routing on the same edge:
  - Goes directly to the shifter if the shifter is empty, or is emitting its last beat this cycle (out_valid && out_ready && cnt==1) while pend_valid==0.
  - Otherwise it goes to the pending register.
- Latency: a word accepted at edge N presents its first beat with out_valid=1 after edge N, when the shifter is free.
- Shifter:
  - out_valid = (cnt!=0), registered.
  - out_data is taken from shift_reg's low OUTWIDTH bits (MSB_FIRST=0) or high OUTWIDTH bits (MSB_FIRST=1).
  - out_last = (cnt==1).
- On out_valid && out_ready:
  - shift_reg shifts by OUTWIDTH toward the emitting end, zero-filling.
  - cnt decrements.
  - On the last beat, if pend_valid, the pending word loads into the shifter on the same edge and pend_valid clears. There is no bubble between words.
- Backpressure: while out_valid && !out_ready, out_data, out_last and cnt are held stable (AXI-Stream rule). out_valid never drops without a handshake.
- Simultaneous events: a last-beat handshake, a pending load and a new input acceptance on one edge is legal. The pending word moves to the shifter and the new word goes to pending.
- Reset mid-word: all beats and the pending word are discarded and no partial word resumes.
- busy = (cnt!=0) || pend_valid.

Decomposition:
- serializer_pkg holds:
  - function clamp_len(len, beats), shared with the future deserializer.
  - beat-order enum ser_order_e {SER_LSB_FIRST, SER_MSB_FIRST}, mapped to MSB_FIRST.
- One sub-module, serializer_shifter. It contains shift_reg, cnt, the direction mux and load/shift control, with ports load, load_data, load_len, advance, out_data, out_last, empty.
- The top level holds the pending buffer and handshake logic.

Test Plan:
- INWIDTH=32, OUTWIDTH=8, MSB_FIRST=0, out_ready=1; in_data=0xDDCCBBAA, in_len=4 -> beats AA,BB,CC,DD on 4 consecutive cycles, out_last only on DD, busy falls after DD.
- Same stimulus with MSB_FIRST=1 -> beats DD,CC,BB,AA, out_last on AA.
- Two words 0x44332211 then 0x88776655, both in_len=4, in_valid held -> 8 gap-free beats 11..88. in_ready drops after the second accept and rises on the first word's last-beat edge.
- out_ready=0 for 3 cycles while out_data=BB -> BB, out_valid=1 and out_last=0 are held. The sequence resumes with CC and no beat is lost or duplicated.
- in_len=0 -> accepted, no out_valid. in_len=6 -> clamped to exactly 4 beats. in_len=2 with 0xDDCCBBAA -> AA,BB, with out_last on BB.
- Assert reset after beat BB with a pending word held -> out_valid=0, busy=0, in_ready=1 immediately. After release, a new word 0x04030201, in_len=4, emits 01..04 only.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serializer family (serializer and the future deserializer).
package serializer_pkg;

  typedef enum logic {
    SER_LSB_FIRST = 1'b0,
    SER_MSB_FIRST = 1'b1
  } ser_order_e;

  // Limits a requested beat count to the number of beats a word actually holds.
  function automatic int clamp_len(input int len, input int beats);
    return (len > beats) ? beats : len;
  endfunction

endpackage

// File: rtl/serializer_shifter.sv
// Shift register and beat counter that emit one OUTWIDTH slice of a loaded word per advance.
module serializer_shifter
  import serializer_pkg::*;
#(
  parameter int         INWIDTH  = 256,
  parameter int         OUTWIDTH = 8,
  parameter int         LENW     = 6,
  parameter ser_order_e ORDER    = SER_LSB_FIRST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [INWIDTH-1:0]  load_data,
  input  logic [LENW-1:0]     load_len,
  input  logic                advance,
  output logic [OUTWIDTH-1:0] out_data,
  output logic                out_last,
  output logic                empty
);

  logic [INWIDTH-1:0] shift_reg;
  logic [LENW-1:0]    cnt;

  // A load always wins over an advance: it only happens when the word in flight is finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt       <= load_len;
    end else if (advance) begin
      if (ORDER == SER_MSB_FIRST) begin
        shift_reg <= shift_reg << OUTWIDTH;
      end else begin
        shift_reg <= shift_reg >> OUTWIDTH;
      end
      cnt <= cnt - LENW'(1);
    end
  end

  generate
    if (ORDER == SER_MSB_FIRST) begin : g_msb
      assign out_data = shift_reg[INWIDTH-1 -: OUTWIDTH];
    end else begin : g_lsb
      assign out_data = shift_reg[OUTWIDTH-1:0];
    end
  endgenerate

  assign out_last = (cnt == LENW'(1));
  assign empty    = (cnt == '0);

endmodule

// File: rtl/stream_serializer.sv
// Width-reducing stream serializer: a one-word pending buffer in front of the shifter keeps
// back-to-back words flowing without bubbles.
module stream_serializer
  import serializer_pkg::*;
#(
  parameter  int INWIDTH   = 256,
  parameter  int OUTWIDTH  = 8,
  parameter  int MSB_FIRST = 0,
  localparam int BEATS     = INWIDTH / OUTWIDTH,
  localparam int LENW      = $clog2(BEATS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INWIDTH-1:0]  in_data,
  input  logic [LENW-1:0]     in_len,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUTWIDTH-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy
);

  localparam ser_order_e ORDER = (MSB_FIRST != 0) ? SER_MSB_FIRST : SER_LSB_FIRST;

  logic [INWIDTH-1:0] pend_data;
  logic [LENW-1:0]    pend_len;
  logic               pend_valid;

  logic               empty;
  logic               accept;
  logic               accept_word;
  logic [LENW-1:0]    eff_len;
  logic               out_fire;
  logic               last_fire;
  logic               shifter_free;
  logic               load;
  logic [INWIDTH-1:0] load_data;
  logic [LENW-1:0]    load_len;

  assign in_ready     = !pend_valid;
  assign accept       = in_valid && in_ready;
  assign eff_len      = LENW'(clamp_len(32'(in_len), BEATS));
  assign accept_word  = accept && (eff_len != '0);
  assign out_valid    = !empty;
  assign out_fire     = out_valid && out_ready;
  assign last_fire    = out_fire && out_last;
  assign shifter_free = empty || last_fire;

  // Pending word has priority for the shifter; a new word only goes straight in when nothing waits.
  assign load      = (last_fire && pend_valid) || (accept_word && shifter_free);
  assign load_data = pend_valid ? pend_data : in_data;
  assign load_len  = pend_valid ? pend_len  : eff_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_data  <= '0;
      pend_len   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (last_fire && pend_valid) begin
        pend_valid <= 1'b0;
      end
      if (accept_word && !shifter_free) begin
        pend_data  <= in_data;
        pend_len   <= eff_len;
        pend_valid <= 1'b1;
      end
    end
  end

  serializer_shifter #(
    .INWIDTH (INWIDTH),
    .OUTWIDTH(OUTWIDTH),
    .LENW    (LENW),
    .ORDER   (ORDER)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .load_len (load_len),
    .advance  (out_fire),
    .out_data (out_data),
    .out_last (out_last),
    .empty    (empty)
  );

  assign busy = !empty || pend_valid;

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench driving an LSB-first and an MSB-first serializer side by side against a beat scoreboard.
module tb_stream_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready_a, out_valid_a, out_last_a, busy_a;
  logic [7:0] out_data_a;
  logic       in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [7:0] out_data_b;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] exp_a, exp_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_last(out_last_a), .busy(busy_a)
  );

  stream_serializer #(.INWIDTH(32), .OUTWIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_last(out_last_b), .busy(busy_b)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every beat the sink takes must be the next one the scoreboard predicted.
  always @(negedge clk) begin
    if (reset && out_ready) begin
      if (out_valid_a) begin
        check_value("beat_expected_a", 32'(q_a.size() != 0), 1);
        if (q_a.size() != 0) begin
          exp_a = q_a.pop_front();
          check_value("beat_data_a", out_data_a, exp_a[7:0]);
          check_value("beat_last_a", out_last_a, exp_a[8]);
        end
      end
      if (out_valid_b) begin
        check_value("beat_expected_b", 32'(q_b.size() != 0), 1);
        if (q_b.size() != 0) begin
          exp_b = q_b.pop_front();
          check_value("beat_data_b", out_data_b, exp_b[7:0]);
          check_value("beat_last_b", out_last_b, exp_b[8]);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] data, input logic [2:0] len);
    int n;
    bit done;
    done     = 1'b0;
    n        = (len > 3'd4) ? 4 : int'(len);
    in_data  = data;
    in_len   = len;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready_a) begin
        for (int k = 0; k < n; k++) begin
          q_a.push_back({k == n - 1, data[8*k +: 8]});
          q_b.push_back({k == n - 1, data[8*(3-k) +: 8]});
        end
        done = 1'b1;
      end
    end
    check_value("accept_timeout", 32'(done), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_output();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(posedge clk);
      #1;
      if (!busy_a && !busy_b) idle = 1'b1;
    end
    check_value("drain_timeout", 32'(idle), 1);
    check_value("beats_left_a", q_a.size(), 0);
    check_value("beats_left_b", q_b.size(), 0);
    check_value("idle_valid_a", out_valid_a, 0);
    check_value("idle_ready_a", in_ready_a, 1);
  endtask

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    check_value("rst_valid_a", out_valid_a, 0);
    check_value("rst_last_a", out_last_a, 0);
    check_value("rst_data_a", out_data_a, 0);
    check_value("rst_busy_a", busy_a, 0);
    check_value("rst_ready_a", in_ready_a, 1);
    check_value("rst_valid_b", out_valid_b, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single word, both orders");
    apply_stimulus(32'hDDCCBBAA, 3'd4);
    check_value("first_valid_a", out_valid_a, 1);
    check_value("first_data_a", out_data_a, 8'hAA);
    check_value("first_data_b", out_data_b, 8'hDD);
    check_value("first_last_a", out_last_a, 0);
    check_value("first_busy_a", busy_a, 1);
    check_output();
    check_value("done_busy_a", busy_a, 0);

    $display("[TB] back-to-back words");
    apply_stimulus(32'h44332211, 3'd4);
    apply_stimulus(32'h88776655, 3'd4);
    check_value("pend_ready_a", in_ready_a, 0);
    check_value("pend_valid_a", out_valid_a, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_value("gapless_valid_a", out_valid_a, 1);
      check_value("gapless_valid_b", out_valid_b, 1);
      if (i == 1) check_value("ready_still_low_a", in_ready_a, 0);
      if (i == 2) check_value("ready_back_a", in_ready_a, 1);
    end
    check_output();

    $display("[TB] backpressure");
    apply_stimulus(32'hDDCCBBAA, 3'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_value("hold_data_a", out_data_a, 8'hBB);
      check_value("hold_data_b", out_data_b, 8'hCC);
      check_value("hold_valid_a", out_valid_a, 1);
      check_value("hold_last_a", out_last_a, 0);
    end
    out_ready = 1'b1;
    check_output();

    $display("[TB] length rules");
    apply_stimulus(32'h12345678, 3'd0);
    check_value("zero_valid_a", out_valid_a, 0);
    check_value("zero_busy_a", busy_a, 0);
    check_value("zero_ready_a", in_ready_a, 1);
    apply_stimulus(32'hDDCCBBAA, 3'd6);
    check_output();
    apply_stimulus(32'hDDCCBBAA, 3'd2);
    check_output();

    $display("[TB] reset mid-word");
    apply_stimulus(32'hDDCCBBAA, 3'd4);
    apply_stimulus(32'h11223344, 3'd4);
    check_value("pre_rst_data_a", out_data_a, 8'hBB);
    check_value("pre_rst_ready_a", in_ready_a, 0);
    reset = 1'b0;
    #1;
    check_value("mid_rst_valid_a", out_valid_a, 0);
    check_value("mid_rst_busy_a", busy_a, 0);
    check_value("mid_rst_ready_a", in_ready_a, 1);
    check_value("mid_rst_valid_b", out_valid_b, 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(32'h04030201, 3'd4);
    check_output();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
